// File: rtl/fetch_inflight_tracker.sv
// Multi-entry in-flight tracker for instruction-fetch requests: holds up to DEPTH
// requests in issue order and presents the head to decode when its data beat returns.
module fetch_inflight_tracker #(
   parameter int               DEPTH       = 4,
   parameter int               VA_W        = 32,
   parameter int               PAYLOAD_W   = 256,
   parameter int               EXC_W       = 5,
   parameter logic [EXC_W-1:0] NO_EXC_CODE = 5'h1F
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enq_valid_i,
   input  logic [VA_W-1:0]              enq_vaddr_i,
   input  logic [PAYLOAD_W-1:0]         enq_payload_i,
   input  logic                         enq_has_exc_i,
   input  logic [EXC_W-1:0]             enq_exc_code_i,
   input  logic                         enq_canceled_i,
   input  logic                         mmu_has_exc_i,
   input  logic [EXC_W-1:0]             mmu_exc_code_i,
   input  logic                         mmu_is_refill_i,
   input  logic                         cancel_i,
   input  logic                         data_ok_i,
   output logic                         allowin_o,
   output logic                         deq_valid_o,
   output logic [VA_W-1:0]              deq_vaddr_o,
   output logic [PAYLOAD_W-1:0]         deq_payload_o,
   output logic                         deq_has_exc_o,
   output logic [EXC_W-1:0]             deq_exc_code_o,
   output logic                         deq_is_refill_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         spurious_o
);

   localparam int               PTR_W   = $clog2(DEPTH);
   localparam int               CNT_W   = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef struct packed {
      logic [VA_W-1:0]      vaddr;
      logic [PAYLOAD_W-1:0] payload;
      logic                 has_exc;
      logic [EXC_W-1:0]     exc_code;
      logic                 is_refill;
      logic                 canceled;
   } entry_t;

   localparam entry_t ENTRY_RST = '{vaddr: '0, payload: '0, has_exc: 1'b0,
                                    exc_code: NO_EXC_CODE, is_refill: 1'b0, canceled: 1'b0};

   entry_t           entry_q [DEPTH];
   entry_t           entry_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop;
   entry_t           new_e;
   entry_t           head_e;

   // NOTE: every combinational output gets a default first (entry_d = entry_q, etc.),
   // so no path through this block can leave a value unassigned and infer a latch.
   always_comb begin
      pop       = data_ok_i && (count_q != '0);
      allowin_o = (count_q < DEPTH_C) || data_ok_i;
      push      = enq_valid_i && allowin_o;

      new_e.vaddr     = enq_vaddr_i;
      new_e.payload   = enq_payload_i;
      new_e.has_exc   = enq_has_exc_i | mmu_has_exc_i;
      new_e.exc_code  = enq_has_exc_i ? enq_exc_code_i
                                      : (mmu_has_exc_i ? mmu_exc_code_i : NO_EXC_CODE);
      new_e.is_refill = !enq_has_exc_i && mmu_has_exc_i && mmu_is_refill_i;
      new_e.canceled  = enq_canceled_i | cancel_i;

      entry_d = entry_q;
      // An entry is occupied when its distance from head is below count; a flush
      // marks all of them, the head being popped included.
      for (int i = 0; i < DEPTH; i++) begin
         if (cancel_i && ({1'b0, PTR_W'(i) - head_q} < count_q)) begin
            entry_d[i].canceled = 1'b1;
         end
      end
      if (push) begin
         entry_d[tail_q] = new_e;
      end

      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(push);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_comb begin
      head_e          = (count_q != '0) ? entry_q[head_q] : ENTRY_RST;
      deq_valid_o     = pop && !head_e.canceled && !cancel_i;
      deq_vaddr_o     = head_e.vaddr;
      deq_payload_o   = head_e.payload;
      deq_has_exc_o   = head_e.has_exc;
      deq_exc_code_o  = head_e.exc_code;
      deq_is_refill_o = head_e.is_refill;
      count_o         = count_q;
      spurious_o      = data_ok_i && (count_q == '0);
   end

   // NOTE: the entry storage is reset along with the pointers so that every field,
   // including exc_code = NO_EXC_CODE, has a defined value straight out of reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= ENTRY_RST;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         entry_q <= entry_d;
      end
   end

endmodule

// File: tb/tb_fetch_inflight_tracker.sv
// Directed bench for fetch_inflight_tracker (DEPTH=4): fill, ordering across wrap,
// flushes, exception merge, spurious beats and mid-operation reset.
module tb_fetch_inflight_tracker;

   logic         clk = 1'b0;
   logic         rst;
   logic         enq_valid_i;
   logic [31:0]  enq_vaddr_i;
   logic [255:0] enq_payload_i;
   logic         enq_has_exc_i;
   logic [4:0]   enq_exc_code_i;
   logic         enq_canceled_i;
   logic         mmu_has_exc_i;
   logic [4:0]   mmu_exc_code_i;
   logic         mmu_is_refill_i;
   logic         cancel_i;
   logic         data_ok_i;
   logic         allowin_o;
   logic         deq_valid_o;
   logic [31:0]  deq_vaddr_o;
   logic [255:0] deq_payload_o;
   logic         deq_has_exc_o;
   logic [4:0]   deq_exc_code_o;
   logic         deq_is_refill_o;
   logic [2:0]   count_o;
   logic         spurious_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_addr;

   fetch_inflight_tracker dut (
      .clk            (clk),
      .rst            (rst),
      .enq_valid_i    (enq_valid_i),
      .enq_vaddr_i    (enq_vaddr_i),
      .enq_payload_i  (enq_payload_i),
      .enq_has_exc_i  (enq_has_exc_i),
      .enq_exc_code_i (enq_exc_code_i),
      .enq_canceled_i (enq_canceled_i),
      .mmu_has_exc_i  (mmu_has_exc_i),
      .mmu_exc_code_i (mmu_exc_code_i),
      .mmu_is_refill_i(mmu_is_refill_i),
      .cancel_i       (cancel_i),
      .data_ok_i      (data_ok_i),
      .allowin_o      (allowin_o),
      .deq_valid_o    (deq_valid_o),
      .deq_vaddr_o    (deq_vaddr_o),
      .deq_payload_o  (deq_payload_o),
      .deq_has_exc_o  (deq_has_exc_o),
      .deq_exc_code_o (deq_exc_code_o),
      .deq_is_refill_o(deq_is_refill_o),
      .count_o        (count_o),
      .spurious_o     (spurious_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Inputs change 1 time unit after the rising edge, well away from the next one.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      enq_valid_i     = 1'b0;
      enq_vaddr_i     = '0;
      enq_payload_i   = '0;
      enq_has_exc_i   = 1'b0;
      enq_exc_code_i  = '0;
      enq_canceled_i  = 1'b0;
      mmu_has_exc_i   = 1'b0;
      mmu_exc_code_i  = '0;
      mmu_is_refill_i = 1'b0;
      cancel_i        = 1'b0;
      data_ok_i       = 1'b0;
   endtask

   task automatic push_one(input logic [31:0] addr);
      idle();
      enq_valid_i = 1'b1;
      enq_vaddr_i = addr;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---- reset state
      rst = 1'b0;
      idle();
      tick();
      tick();
      check("rst_count",   64'(count_o),        64'h0);
      check("rst_allowin", 64'(allowin_o),      64'h1);
      check("rst_valid",   64'(deq_valid_o),    64'h0);
      check("rst_spur",    64'(spurious_o),     64'h0);
      check("rst_code",    64'(deq_exc_code_o), 64'h1F);
      check("rst_vaddr",   64'(deq_vaddr_o),    64'h0);
      rst = 1'b1;
      tick();

      // ---- fill to DEPTH, then push+pop on full
      push_one(32'h100);
      push_one(32'h110);
      push_one(32'h120);
      push_one(32'h130);
      idle();
      #1;
      check("full_count",   64'(count_o),     64'h4);
      check("full_allowin", 64'(allowin_o),   64'h0);
      enq_valid_i = 1'b1;
      enq_vaddr_i = 32'h140;
      data_ok_i   = 1'b1;
      #1;
      check("full_pp_allowin", 64'(allowin_o),   64'h1);
      check("full_pp_valid",   64'(deq_valid_o), 64'h1);
      check("full_pp_vaddr",   64'(deq_vaddr_o), 64'h100);
      tick();
      idle();
      #1;
      check("full_pp_count", 64'(count_o), 64'h4);
      for (int k = 1; k <= 4; k++) begin
         data_ok_i = 1'b1;
         #1;
         check("fill_drain_valid", 64'(deq_valid_o), 64'h1);
         check("fill_drain_vaddr", 64'(deq_vaddr_o), 64'(32'h100 + 32'(16 * k)));
         tick();
      end
      idle();
      #1;
      check("fill_empty_count", 64'(count_o), 64'h0);

      // ---- order across pointer wrap: push every cycle, pop on two of every three
      for (int i = 0; i < 10; i++) begin
         idle();
         enq_valid_i = 1'b1;
         enq_vaddr_i = 32'h1000 + 32'(16 * i);
         data_ok_i   = (i % 3) != 0;
         #1;
         if (data_ok_i) begin
            exp_addr = exp_q.pop_front();
            check("wrap_valid", 64'(deq_valid_o), 64'h1);
            check("wrap_vaddr", 64'(deq_vaddr_o), 64'(exp_addr));
         end
         exp_q.push_back(enq_vaddr_i);
         tick();
      end
      idle();
      #1;
      check("wrap_count", 64'(count_o), 64'(exp_q.size()));
      while (exp_q.size() > 0) begin
         data_ok_i = 1'b1;
         #1;
         exp_addr = exp_q.pop_front();
         check("wrap_drain_valid", 64'(deq_valid_o), 64'h1);
         check("wrap_drain_vaddr", 64'(deq_vaddr_o), 64'(exp_addr));
         tick();
      end
      idle();
      #1;
      check("wrap_empty_count", 64'(count_o), 64'h0);

      // ---- flush with three requests in flight, fourth issued after
      push_one(32'h2000);
      push_one(32'h2010);
      push_one(32'h2020);
      idle();
      cancel_i = 1'b1;
      tick();
      push_one(32'h2030);
      idle();
      for (int k = 0; k < 3; k++) begin
         data_ok_i = 1'b1;
         #1;
         check("cxl_valid", 64'(deq_valid_o), 64'h0);
         check("cxl_vaddr", 64'(deq_vaddr_o), 64'(32'h2000 + 32'(16 * k)));
         tick();
      end
      data_ok_i = 1'b1;
      #1;
      check("cxl_after_valid", 64'(deq_valid_o), 64'h1);
      check("cxl_after_vaddr", 64'(deq_vaddr_o), 64'h2030);
      tick();
      idle();

      // ---- cancel in the same cycle as the returning beat
      push_one(32'h3000);
      push_one(32'h3010);
      idle();
      data_ok_i = 1'b1;
      cancel_i  = 1'b1;
      #1;
      check("samecxl_valid", 64'(deq_valid_o), 64'h0);
      check("samecxl_vaddr", 64'(deq_vaddr_o), 64'h3000);
      tick();
      idle();
      #1;
      check("samecxl_count", 64'(count_o), 64'h1);
      data_ok_i = 1'b1;
      #1;
      check("samecxl_second_valid", 64'(deq_valid_o), 64'h0);
      tick();
      // a request pushed during a flush is itself canceled
      idle();
      enq_valid_i = 1'b1;
      enq_vaddr_i = 32'h3020;
      cancel_i    = 1'b1;
      tick();
      idle();
      data_ok_i = 1'b1;
      #1;
      check("pushcxl_valid", 64'(deq_valid_o), 64'h0);
      check("pushcxl_vaddr", 64'(deq_vaddr_o), 64'h3020);
      tick();
      idle();
      #1;
      check("pushcxl_count", 64'(count_o), 64'h0);

      // ---- exception merge
      idle();
      enq_valid_i     = 1'b1;
      enq_vaddr_i     = 32'h4000;
      mmu_has_exc_i   = 1'b1;
      mmu_exc_code_i  = 5'h02;
      mmu_is_refill_i = 1'b1;
      tick();
      idle();
      enq_valid_i     = 1'b1;
      enq_vaddr_i     = 32'h4010;
      enq_has_exc_i   = 1'b1;
      enq_exc_code_i  = 5'h04;
      mmu_has_exc_i   = 1'b1;
      mmu_exc_code_i  = 5'h07;
      mmu_is_refill_i = 1'b1;
      tick();
      idle();
      enq_valid_i   = 1'b1;
      enq_vaddr_i   = 32'h4020;
      enq_payload_i = {32'hCAFE_F00D, 160'h0, 64'h0123_4567_89AB_CDEF};
      tick();
      idle();
      data_ok_i = 1'b1;
      #1;
      check("mmu_valid",  64'(deq_valid_o),     64'h1);
      check("mmu_hasexc", 64'(deq_has_exc_o),   64'h1);
      check("mmu_code",   64'(deq_exc_code_o),  64'h02);
      check("mmu_refill", 64'(deq_is_refill_o), 64'h1);
      tick();
      #1;
      check("enq_hasexc", 64'(deq_has_exc_o),   64'h1);
      check("enq_code",   64'(deq_exc_code_o),  64'h04);
      check("enq_refill", 64'(deq_is_refill_o), 64'h0);
      tick();
      #1;
      check("noexc_hasexc", 64'(deq_has_exc_o),       64'h0);
      check("noexc_code",   64'(deq_exc_code_o),      64'h1F);
      check("payload_lo",   deq_payload_o[63:0],      64'h0123_4567_89AB_CDEF);
      check("payload_hi",   64'(deq_payload_o[255:224]), 64'hCAFE_F00D);
      tick();
      idle();

      // ---- spurious data beat on an empty tracker
      data_ok_i = 1'b1;
      #1;
      check("spur_pulse", 64'(spurious_o),  64'h1);
      check("spur_valid", 64'(deq_valid_o), 64'h0);
      tick();
      idle();
      #1;
      check("spur_count", 64'(count_o),    64'h0);
      check("spur_clear", 64'(spurious_o), 64'h0);
      enq_valid_i = 1'b1;
      enq_vaddr_i = 32'h5000;
      data_ok_i   = 1'b1;
      #1;
      check("spur_push_pulse", 64'(spurious_o),  64'h1);
      check("spur_push_valid", 64'(deq_valid_o), 64'h0);
      tick();
      idle();
      #1;
      check("spur_push_count", 64'(count_o), 64'h1);
      data_ok_i = 1'b1;
      #1;
      check("spur_push_pop_valid", 64'(deq_valid_o), 64'h1);
      check("spur_push_pop_vaddr", 64'(deq_vaddr_o), 64'h5000);
      tick();
      idle();

      // ---- reset with entries outstanding
      push_one(32'h6000);
      push_one(32'h6010);
      push_one(32'h6020);
      idle();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("midrst_count",   64'(count_o),        64'h0);
      check("midrst_allowin", 64'(allowin_o),      64'h1);
      check("midrst_code",    64'(deq_exc_code_o), 64'h1F);
      check("midrst_vaddr",   64'(deq_vaddr_o),    64'h0);
      data_ok_i = 1'b1;
      #1;
      check("midrst_spur",  64'(spurious_o),  64'h1);
      check("midrst_valid", 64'(deq_valid_o), 64'h0);
      tick();
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_inflight_tracker.md
Name: fetch_inflight_tracker

Overview:
- Parametrised successor of the single-entry second-stage fetch tracker.
- Holds up to DEPTH outstanding instruction-fetch requests in issue order, between request acceptance and return of the matching inst_data_ok beat.
- Per-entry cancel bits handle flushes; FCT and MMU exception information is merged at enqueue time.
- Presents the head entry to decode when data returns.

Parameters:
- DEPTH, 4: maximum outstanding requests; power of two, ≥2.
- VA_W, 32: virtual address width.
- PAYLOAD_W, 256: opaque per-request side-band (prediction/checkpoint bundle), passed through unchanged.
- EXC_W, 5: exception code width.
- NO_EXC_CODE, 5'h1F: exception code value meaning "none".

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- enq_valid_i  in  1  new request issued this cycle
- enq_vaddr_i  in  VA_W  request virtual address
- enq_payload_i  in  PAYLOAD_W  side-band bundle
- enq_has_exc_i  in  1  upstream exception already present
- enq_exc_code_i  in  EXC_W  upstream exception code
- enq_canceled_i  in  1  request already canceled upstream
- mmu_has_exc_i  in  1  MMU exception for this request
- mmu_exc_code_i  in  EXC_W  MMU exception code
- mmu_is_refill_i  in  1  MMU exception is TLB refill
- cancel_i  in  1  flush (branch-check cancel | exception | BPU recovery), pre-ORed
- data_ok_i  in  1  bus returns data for the oldest request
- allowin_o  out  1  enqueue permitted this cycle
- deq_valid_o  out  1  head data valid for decode
- deq_vaddr_o  out  VA_W  head address
- deq_payload_o  out  PAYLOAD_W  head side-band
- deq_has_exc_o  out  1  head exception flag
- deq_exc_code_o  out  EXC_W  head exception code
- deq_is_refill_o  out  1  head refill flag
- count_o  out  $clog2(DEPTH+1)  occupied entries
- spurious_o  out  1  one-cycle pulse: data_ok_i arrived while empty

Behaviour:
- Storage: circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping naturally, plus a count register.
  - Per entry: vaddr, payload, has_exc, exc_code, is_refill, canceled.
- Reset (rst=0 at a clk edge), including mid-operation:
  - Pointers, count and all entry fields clear; exc_code fields are set to NO_EXC_CODE.
  - allowin_o=1, deq_valid_o=0, count_o=0, spurious_o=0.
  - While empty, all deq_* fields read 0; deq_exc_code_o reads NO_EXC_CODE.
- pop = data_ok_i && count!=0. Head advances at the edge.
- push = enq_valid_i && allowin_o. Tail advances at the edge.
- allowin_o = (count<DEPTH) || data_ok_i. A full queue accepts a push in the same cycle as a pop.
- Simultaneous push and pop: count unchanged.
  - When count=0 and push+data_ok occur together, there is no pop: the returned data never belongs to the new request, spurious_o=1, and the new entry is stored.
- Enqueue merge:
  - has_exc = enq_has_exc_i | mmu_has_exc_i.
  - exc_code = enq_has_exc_i ? enq_exc_code_i : (mmu_has_exc_i ? mmu_exc_code_i : NO_EXC_CODE).
  - is_refill = !enq_has_exc_i & mmu_has_exc_i & mmu_is_refill_i.
  - canceled = enq_canceled_i | cancel_i.
- cancel_i sets canceled on every occupied entry at the edge, including the head being popped and any entry pushed in the same cycle.
- deq_valid_o = pop && !head.canceled && !cancel_i. A same-cycle cancel suppresses the returning beat (new behaviour versus the single-entry tracker).
- Canceled entries still wait for and consume their own data_ok_i; no entry is dropped without a data beat.
- deq_* fields are combinational from the head entry. Latency from data_ok_i to deq_valid_o is 0 cycles.
- No head-of-line bypass for exception entries: they also retire on data_ok_i.
- count_o is registered and never exceeds DEPTH. Push on a full queue without a pop is impossible because allowin_o=0.

Test Plan:
- Fill: DEPTH=4, 4 pushes, no data_ok → count_o=4, allowin_o=0. Push+data_ok same cycle → count_o stays 4, deq_vaddr_o=first address, deq_valid_o=1.
- Order and wrap: 10 pushes interleaved with pops (addresses 0x1000+16·i) → deq_vaddr_o returns exactly in order across pointer wrap, no gaps.
- Cancel mid-flight: 3 entries outstanding, cancel_i pulse, then 3 data_ok → deq_valid_o=0 for all three; a fourth entry pushed after the cancel pops with deq_valid_o=1.
- Same-cycle cancel: data_ok_i=1 and cancel_i=1 with head uncanceled → deq_valid_o=0, head retired, count decrements.
- Exception merge:
  - enq_has_exc=0, mmu_has_exc=1, code 5'h02, refill=1 → on pop deq_has_exc_o=1, code 5'h02, deq_is_refill_o=1.
  - enq_has_exc=1, code 5'h04, mmu_has_exc=1 → code 5'h04, refill=0.
- Spurious/reset: data_ok with count=0 → spurious_o=1, count_o=0. rst=0 with 3 entries queued → next cycle count_o=0, allowin_o=1, deq_exc_code_o=5'h1F.
